// File: rtl/even_issue_scheduler.sv
// Even-pipe issue control: a countdown scoreboard of in-flight destinations
// gates issue on RAW hazards and shared-writeback slot conflicts.
module even_issue_scheduler #(
  parameter int unsigned LAT_FP  = 6,
  parameter int unsigned LAT_FPI = 7,
  parameter int unsigned LAT_FX2 = 4,
  parameter int unsigned LAT_B1  = 4,
  parameter int unsigned LAT_FX1 = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       unit,
  input  logic             fp_int,
  input  logic [6:0]       rt_addr,
  input  logic             reg_write,
  input  logic [6:0]       ra_addr,
  input  logic [6:0]       rb_addr,
  input  logic [6:0]       rc_addr,
  input  logic             ra_use,
  input  logic             rb_use,
  input  logic             rc_use,
  input  logic             flush,
  output logic             issue,
  output logic             stall,
  output logic             stall_raw,
  output logic             stall_wb,
  output logic [2:0]       inflight,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] LP_FP  = 3'(LAT_FP);
  localparam logic [2:0] LP_FPI = 3'(LAT_FPI);
  localparam logic [2:0] LP_FX2 = 3'(LAT_FX2);
  localparam logic [2:0] LP_B1  = 3'(LAT_B1);
  localparam logic [2:0] LP_FX1 = 3'(LAT_FX1);

  // Slot k holds an entry k cycles away from the forwarding network
  logic [7:1]       r_v;
  logic [6:0]       r_addr [1:7];
  logic [CNT_W-1:0] r_cnt;

  logic [2:0] w_lat;
  logic       w_raw;
  logic       w_wb;
  logic [2:0] w_pop;

  always_comb begin
    w_lat = LP_FX1;
    case (unit)
      2'd0:    w_lat = fp_int ? LP_FPI : LP_FP;
      2'd1:    w_lat = LP_FX2;
      2'd2:    w_lat = LP_B1;
      default: w_lat = LP_FX1;
    endcase
  end

  always_comb begin
    w_raw = 1'b0;
    w_wb  = 1'b0;
    w_pop = 3'd0;
    for (int k = 1; k <= 7; k++) begin
      w_raw = w_raw | (r_v[k] & ((ra_use & (r_addr[k] == ra_addr)) |
                                 (rb_use & (r_addr[k] == rb_addr)) |
                                 (rc_use & (r_addr[k] == rc_addr))));
      w_pop = w_pop + {2'b00, r_v[k]};
    end
    // An entry one slot above L would shift into slot L as the new one lands
    for (int k = 1; k <= 6; k++) begin
      if (w_lat == 3'(k)) w_wb = reg_write & r_v[k+1];
    end
  end

  assign stall_raw = w_raw;
  assign stall_wb  = w_wb;
  assign issue     = in_valid & ~flush & ~w_raw & ~w_wb;
  assign stall     = in_valid & ~issue & ~flush;
  assign inflight  = w_pop;
  assign stall_cnt = r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= '0;
      for (int k = 1; k <= 7; k++) r_addr[k] <= '0;
    end else begin
      for (int k = 1; k <= 6; k++) begin
        r_v[k]    <= r_v[k+1];
        r_addr[k] <= r_addr[k+1];
      end
      r_v[7]    <= 1'b0;
      r_addr[7] <= '0;
      if (issue && reg_write) begin
        r_v[w_lat]    <= 1'b1;
        r_addr[w_lat] <= rt_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (stall && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_even_issue_scheduler.sv
// Directed scoreboard bench for even_issue_scheduler: expectations are queued
// while stimulus is driven and compared when the cycle's outputs are sampled.
module tb_even_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, fp_int, reg_write, flush;
  logic [1:0]  unit;
  logic [6:0]  rt_addr, ra_addr, rb_addr, rc_addr;
  logic        ra_use, rb_use, rc_use;
  logic        issue, stall, stall_raw, stall_wb;
  logic [2:0]  inflight;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  localparam int S_ISSUE = 0, S_STALL = 1, S_RAW = 2, S_WB = 3, S_INFL = 4, S_CNT = 5;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  even_issue_scheduler dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .unit(unit), .fp_int(fp_int),
    .rt_addr(rt_addr), .reg_write(reg_write),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .ra_use(ra_use), .rb_use(rb_use), .rc_use(rc_use), .flush(flush),
    .issue(issue), .stall(stall), .stall_raw(stall_raw), .stall_wb(stall_wb),
    .inflight(inflight), .stall_cnt(stall_cnt)
  );

  function automatic int sig(int sel);
    case (sel)
      S_ISSUE: return int'(issue);
      S_STALL: return int'(stall);
      S_RAW:   return int'(stall_raw);
      S_WB:    return int'(stall_wb);
      S_INFL:  return int'(inflight);
      default: return int'(stall_cnt);
    endcase
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, sig(e.sel), e.exp);
    end
  endtask

  // Inputs set before calling belong to the current cycle; returns #1 after the next edge
  task automatic cyc();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; unit = 0; fp_int = 0; rt_addr = 0; reg_write = 0; flush = 0;
    ra_addr = 0; rb_addr = 0; rc_addr = 0; ra_use = 0; rb_use = 0; rc_use = 0;
  endtask

  task automatic ins(input logic [1:0] u, input logic fi, input logic [6:0] rt, input logic rw);
    in_valid = 1; unit = u; fp_int = fi; rt_addr = rt; reg_write = rw;
  endtask

  task automatic do_reset(input string tag);
    idle();
    reset = 1;
    #1;
    expect_val({tag, "_rst_issue"}, S_ISSUE, 0);
    expect_val({tag, "_rst_stall"}, S_STALL, 0);
    expect_val({tag, "_rst_raw"},   S_RAW, 0);
    expect_val({tag, "_rst_wb"},    S_WB, 0);
    expect_val({tag, "_rst_infl"},  S_INFL, 0);
    expect_val({tag, "_rst_cnt"},   S_CNT, 0);
    drain();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    #12;
    do_reset("init");

    // FX1 write r5: L=2
    ins(2'd3, 0, 7'd5, 1);
    expect_val("fx1_issue", S_ISSUE, 1);
    expect_val("fx1_infl0", S_INFL, 0);
    cyc();
    idle();
    expect_val("fx1_infl1", S_INFL, 1); cyc();
    expect_val("fx1_infl2", S_INFL, 1); cyc();
    expect_val("fx1_infl3", S_INFL, 0); cyc();

    // FP write r10 (L=6), consumer reads r10 through rb
    do_reset("raw");
    ins(2'd0, 0, 7'd10, 1);
    expect_val("raw_prod_issue", S_ISSUE, 1);
    cyc();
    ins(2'd3, 0, 7'd11, 0);
    rb_addr = 7'd10; rb_use = 1;
    for (int i = 1; i <= 6; i++) begin
      expect_val($sformatf("raw_c%0d_raw", i), S_RAW, 1);
      expect_val($sformatf("raw_c%0d_stall", i), S_STALL, 1);
      expect_val($sformatf("raw_c%0d_issue", i), S_ISSUE, 0);
      cyc();
    end
    expect_val("raw_c7_issue", S_ISSUE, 1);
    expect_val("raw_c7_raw", S_RAW, 0);
    expect_val("raw_c7_cnt", S_CNT, 6);
    cyc();
    idle();

    // FX2 write r3 (L=4) then FX1 write r4 (L=2) two cycles later
    do_reset("wb");
    ins(2'd1, 0, 7'd3, 1);
    expect_val("wb_prod_issue", S_ISSUE, 1);
    cyc();
    idle(); cyc();
    ins(2'd3, 0, 7'd4, 1);
    expect_val("wb_c2_wb", S_WB, 1);
    expect_val("wb_c2_stall", S_STALL, 1);
    expect_val("wb_c2_issue", S_ISSUE, 0);
    expect_val("wb_c2_raw", S_RAW, 0);
    cyc();
    expect_val("wb_c3_issue", S_ISSUE, 1);
    expect_val("wb_c3_wb", S_WB, 0);
    cyc();
    idle();
    expect_val("wb_c4_infl", S_INFL, 2);
    expect_val("wb_c4_cnt", S_CNT, 1);
    cyc();

    // Same pair, second instruction without register write
    do_reset("nowr");
    ins(2'd1, 0, 7'd3, 1); cyc();
    idle(); cyc();
    ins(2'd3, 0, 7'd4, 0);
    expect_val("nowr_issue", S_ISSUE, 1);
    expect_val("nowr_stall", S_STALL, 0);
    expect_val("nowr_wb", S_WB, 0);
    cyc();
    idle();
    expect_val("nowr_infl", S_INFL, 1);
    cyc();

    // L=7 never conflicts even with slot 7 occupied
    do_reset("l7");
    ins(2'd0, 1, 7'd6, 1); cyc();
    ins(2'd0, 1, 7'd7, 1);
    expect_val("l7_wb", S_WB, 0);
    expect_val("l7_issue", S_ISSUE, 1);
    expect_val("l7_raw", S_RAW, 0);
    cyc();
    idle();
    expect_val("l7_infl", S_INFL, 2);
    cyc();

    // Flush on a RAW-stalled candidate
    do_reset("fl");
    ins(2'd1, 0, 7'd8, 1); cyc();
    ins(2'd3, 0, 7'd9, 1);
    ra_addr = 7'd8; ra_use = 1;
    expect_val("fl_c1_stall", S_STALL, 1);
    cyc();
    flush = 1;
    expect_val("fl_c2_issue", S_ISSUE, 0);
    expect_val("fl_c2_stall", S_STALL, 0);
    expect_val("fl_c2_raw", S_RAW, 1);
    expect_val("fl_c2_cnt", S_CNT, 1);
    cyc();
    flush = 0;
    expect_val("fl_c3_stall", S_STALL, 1);
    expect_val("fl_c3_cnt", S_CNT, 1);
    cyc();
    expect_val("fl_c4_cnt", S_CNT, 2);
    cyc();
    idle();

    // Asynchronous reset mid-cycle with three entries in flight
    do_reset("ar");
    ins(2'd0, 0, 7'd1, 1); cyc();
    ins(2'd0, 0, 7'd2, 1); cyc();
    ins(2'd0, 0, 7'd3, 1); cyc();
    ins(2'd3, 0, 7'd20, 0);
    ra_addr = 7'd1; ra_use = 1;
    expect_val("ar_pre_infl", S_INFL, 3);
    expect_val("ar_pre_raw", S_RAW, 1);
    #1;
    drain();
    reset = 1;
    #1;
    expect_val("ar_post_infl", S_INFL, 0);
    expect_val("ar_post_raw", S_RAW, 0);
    expect_val("ar_post_cnt", S_CNT, 0);
    drain();
    idle();
    @(posedge clk);
    #1;
    reset = 0;

    // Self-dependent L=7 instruction held at the input: 7 stalls per 8 cycles
    ins(2'd0, 1, 7'd1, 1);
    ra_addr = 7'd1; ra_use = 1;
    expect_val("sat_c0_issue", S_ISSUE, 1);
    cyc();
    for (int i = 1; i <= 7; i++) cyc();
    expect_val("sat_c8_issue", S_ISSUE, 1);
    expect_val("sat_c8_cnt", S_CNT, 7);
    cyc();
    repeat (80000) @(posedge clk);
    #1;
    expect_val("sat_cnt", S_CNT, 65535);
    drain();
    repeat (16) @(posedge clk);
    #1;
    expect_val("sat_hold", S_CNT, 65535);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
